// File: rtl/tc_byteen_timer.sv
// Memory-mapped down-counting timer with byte-lane writes and a CP0 interrupt request.
// Registers: CTRL (IM/Mode/Enable), PRESET, COUNT (read-only), and a reserved slot.
module tc_byteen_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_clr;
  logic        addr_unused;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:2];
  assign addr_unused = ^addr[1:0];

  // CTRL only accepts the low lane; any CTRL or PRESET access drops a pending flag.
  assign wr_ctrl   = we && hit && (offset == 2'd0) && byteen[0];
  assign wr_preset = we && hit && (offset == 2'd1);
  assign wr_clr    = we && hit && ((offset == 2'd0) || (offset == 2'd1));

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      // A CPU write to CTRL overrides the one-shot Enable clear from INT.
      if (wr_ctrl) begin
        ctrl <= wdata[3:0];
      end else if ((state == INT) && (ctrl[2:1] != 2'b01)) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_preset) preset <= merge_bytes(preset, wdata, byteen);

      case (state)
        IDLE: if (ctrl[0]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (count == 32'd0) begin
            state    <= INT;
            irq_flag <= 1'b1;
          end else begin
            count <= count - 32'd1;
          end
        end
        INT: begin
          if (ctrl[2:1] == 2'b01) begin
            state    <= LOAD;
            irq_flag <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_clr) irq_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        2'd0:    rdata = {28'd0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl[3];

endmodule
